mouse_position_tracker: RTL and testbench

Parametrised PS/2 mouse position tracker and bus peripheral. It sits between the mouse master state machine's packet outputs and the 8-bit processor bus. It accumulates X/Y position at configurable coordinate width, screen limits and sensitivity, and accumulates scroll-wheel movement. It exposes coherent multi-byte registers, writable position and control, a packet counter, and a maskable interrupt with acknowledge.

---
 rtl/mouse_pkg.sv | 39 +++
 rtl/mouse_position_tracker_if.sv | 27 ++
 rtl/mouse_axis_accumulator.sv | 89 ++++++++
 rtl/mouse_position_tracker.sv | 139 +++++++++++++
 tb/tb_mouse_position_tracker.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mouse_pkg.sv
// Shared constants for the PS/2 mouse position tracker:
// register offsets, CTRL/STATUS bit positions, wheel bounds.
package mouse_pkg;

    localparam logic [2:0] OFF_STATUS = 3'd0;
    localparam logic [2:0] OFF_XL     = 3'd1;
    localparam logic [2:0] OFF_XH     = 3'd2;
    localparam logic [2:0] OFF_YL     = 3'd3;
    localparam logic [2:0] OFF_YH     = 3'd4;
    localparam logic [2:0] OFF_WHEEL  = 3'd5;
    localparam logic [2:0] OFF_CTRL   = 3'd6;
    localparam logic [2:0] OFF_PKTCNT = 3'd7;

    localparam int CTRL_INV_Y    = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_SENS_LSB = 2;
    localparam int CTRL_BTN_ONLY = 4;

    localparam logic [7:0] CTRL_RESET = 8'h03;
    localparam logic [7:0] CTRL_WMASK = 8'h1F;

    localparam int ST_Y_OVF   = 7;
    localparam int ST_X_OVF   = 6;
    localparam int ST_Y_SIGN  = 5;
    localparam int ST_X_SIGN  = 4;
    localparam int ST_BTN_MSB = 2;

    localparam int WHEEL_MAX = 127;
    localparam int WHEEL_MIN = -128;

    function automatic logic [7:0] wheelSat(
        input logic signed [8:0] s
    );
        if (int'(s) > WHEEL_MAX) return 8'(WHEEL_MAX);
        if (int'(s) < WHEEL_MIN) return 8'(WHEEL_MIN);
        return s[7:0];
    endfunction

endpackage

// File: rtl/mouse_position_tracker_if.sv
// Packet and processor-bus signals of the mouse tracker.
// The tristate data lane stays a plain port on the top.
interface mouse_position_tracker_if;

    logic       PKT_VALID;
    logic [7:0] PKT_STATUS;
    logic [7:0] PKT_DX;
    logic [7:0] PKT_DY;
    logic [3:0] PKT_DZ;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    logic       BUS_INTERRUPT_RAISE;
    logic       BUS_INTERRUPT_ACK;

    modport master (
        output PKT_VALID, PKT_STATUS, PKT_DX, PKT_DY, PKT_DZ,
        output BUS_ADDR, BUS_WE, BUS_INTERRUPT_ACK,
        input  BUS_INTERRUPT_RAISE
    );

    modport slave (
        input  PKT_VALID, PKT_STATUS, PKT_DX, PKT_DY, PKT_DZ,
        input  BUS_ADDR, BUS_WE, BUS_INTERRUPT_ACK,
        output BUS_INTERRUPT_RAISE
    );

endinterface

// File: rtl/mouse_axis_accumulator.sv
// One position axis: delta extension, sensitivity, clamping,
// plus coherent shadow-low/commit-high access.
module mouse_axis_accumulator
    import mouse_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int LIMIT   = 640
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       pktValid,
    input  logic [7:0] rawDelta,
    input  logic       deltaSign,
    input  logic       deltaOvf,
    input  logic [1:0] sens,
    input  logic       invert,
    input  logic       wrLow,
    input  logic       wrHigh,
    input  logic [7:0] wrData,
    input  logic       rdLow,
    input  logic       rdHigh,
    output logic [7:0] lowByte,
    output logic [7:0] highByte
);

    localparam int W = COORD_W + 4;
    localparam logic signed [W-1:0] MAX_S = W'(LIMIT - 1);
    localparam logic [15:0] MAX_U = 16'(LIMIT - 1);
    localparam logic [COORD_W-1:0] MAX_P = COORD_W'(LIMIT - 1);
    localparam logic [COORD_W-1:0] MID_P = COORD_W'(LIMIT / 2);

    logic [COORD_W-1:0] pos;
    logic [COORD_W-1:0] pktPos;
    logic [COORD_W-1:0] commitPos;
    logic [7:0]         wrShadow;
    logic [7:0]         rdShadow;
    logic               rdShadowValid;
    logic [7:0]         liveHigh;
    logic [15:0]        wrVal;
    logic signed [8:0]  delta9;
    logic signed [W-1:0] deltaShift;
    logic signed [W-1:0] posExt;
    logic signed [W-1:0] sum;

    // Overflowed packets saturate to the 9-bit extremes.
    always_comb begin
        delta9 = {deltaSign, rawDelta};
        if (deltaOvf) delta9 = deltaSign ? 9'h100 : 9'h0FF;
    end

    assign deltaShift = {{(W-9){delta9[8]}}, delta9} << sens;
    assign posExt = {4'b0, pos};
    assign sum = invert ? posExt - deltaShift
                        : posExt + deltaShift;

    always_comb begin
        pktPos = sum[COORD_W-1:0];
        if (sum[W-1])         pktPos = '0;
        else if (sum > MAX_S) pktPos = MAX_P;
    end

    assign wrVal = {wrData, wrShadow};
    assign commitPos = (wrVal > MAX_U) ? MAX_P
                                       : wrVal[COORD_W-1:0];

    assign liveHigh = 8'(pos >> 8);
    assign lowByte  = pos[7:0];
    assign highByte = rdShadowValid ? rdShadow : liveHigh;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pos           <= MID_P;
            wrShadow      <= 8'h00;
            rdShadow      <= 8'h00;
            rdShadowValid <= 1'b0;
        end else begin
            if (wrHigh)        pos <= commitPos;
            else if (pktValid) pos <= pktPos;
            if (wrLow) wrShadow <= wrData;
            if (rdLow) begin
                rdShadow      <= liveHigh;
                rdShadowValid <= 1'b1;
            end else if (rdHigh) begin
                rdShadowValid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mouse_position_tracker.sv
// PS/2 mouse position tracker: bus decode, wheel, packet
// counter, status and interrupt around two axis accumulators.
module mouse_position_tracker
    import mouse_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hA0,
    parameter int         COORD_W   = 10,
    parameter int         LIMIT_X   = 640,
    parameter int         LIMIT_Y   = 480
) (
    input  logic     CLK,
    input  logic     RESET,
    mouse_position_tracker_if.slave bus,
    inout  wire [7:0] BUS_DATA
);

    logic [7:0]        off;
    logic              hit;
    logic [7:0]        sel;
    logic [7:0]        rdSel;
    logic [7:0]        wrSel;
    logic [7:0]        status;
    logic [7:0]        ctrl;
    logic [7:0]        pktCnt;
    logic [7:0]        wheel;
    logic [2:0]        prevBtn;
    logic              irq;
    logic              irqSet;
    logic              rdValid;
    logic [7:0]        rdData;
    logic [7:0]        rdMux;
    logic [7:0]        dzExt;
    logic signed [8:0] wheelSum;
    logic [7:0]        xLow, xHigh, yLow, yHigh;

    assign off   = bus.BUS_ADDR - BASE_ADDR;
    assign hit   = off < 8'd8;
    assign sel   = hit ? (8'b1 << off[2:0]) : 8'b0;
    assign rdSel = bus.BUS_WE ? 8'b0 : sel;
    assign wrSel = bus.BUS_WE ? sel : 8'b0;

    mouse_axis_accumulator #(
        .COORD_W(COORD_W),
        .LIMIT  (LIMIT_X)
    ) xAxis (
        .CLK      (CLK),
        .RESET    (RESET),
        .pktValid (bus.PKT_VALID),
        .rawDelta (bus.PKT_DX),
        .deltaSign(bus.PKT_STATUS[ST_X_SIGN]),
        .deltaOvf (bus.PKT_STATUS[ST_X_OVF]),
        .sens     (ctrl[CTRL_SENS_LSB +: 2]),
        .invert   (1'b0),
        .wrLow    (wrSel[OFF_XL]),
        .wrHigh   (wrSel[OFF_XH]),
        .wrData   (BUS_DATA),
        .rdLow    (rdSel[OFF_XL]),
        .rdHigh   (rdSel[OFF_XH]),
        .lowByte  (xLow),
        .highByte (xHigh)
    );

    mouse_axis_accumulator #(
        .COORD_W(COORD_W),
        .LIMIT  (LIMIT_Y)
    ) yAxis (
        .CLK      (CLK),
        .RESET    (RESET),
        .pktValid (bus.PKT_VALID),
        .rawDelta (bus.PKT_DY),
        .deltaSign(bus.PKT_STATUS[ST_Y_SIGN]),
        .deltaOvf (bus.PKT_STATUS[ST_Y_OVF]),
        .sens     (ctrl[CTRL_SENS_LSB +: 2]),
        .invert   (ctrl[CTRL_INV_Y]),
        .wrLow    (wrSel[OFF_YL]),
        .wrHigh   (wrSel[OFF_YH]),
        .wrData   (BUS_DATA),
        .rdLow    (rdSel[OFF_YL]),
        .rdHigh   (rdSel[OFF_YH]),
        .lowByte  (yLow),
        .highByte (yHigh)
    );

    assign dzExt    = {{4{bus.PKT_DZ[3]}}, bus.PKT_DZ};
    assign wheelSum = {wheel[7], wheel} + {dzExt[7], dzExt};

    assign irqSet = bus.PKT_VALID && ctrl[CTRL_IRQ_EN] &&
        (!ctrl[CTRL_BTN_ONLY] ||
         bus.PKT_STATUS[ST_BTN_MSB:0] != prevBtn);

    always_comb begin
        rdMux = 8'h00;
        unique case (1'b1)
            sel[OFF_STATUS]: rdMux = status;
            sel[OFF_XL]:     rdMux = xLow;
            sel[OFF_XH]:     rdMux = xHigh;
            sel[OFF_YL]:     rdMux = yLow;
            sel[OFF_YH]:     rdMux = yHigh;
            sel[OFF_WHEEL]:  rdMux = wheel;
            sel[OFF_CTRL]:   rdMux = ctrl;
            sel[OFF_PKTCNT]: rdMux = pktCnt;
            default:         rdMux = 8'h00;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            status  <= 8'h00;
            ctrl    <= CTRL_RESET;
            pktCnt  <= 8'h00;
            wheel   <= 8'h00;
            prevBtn <= 3'b000;
            irq     <= 1'b0;
            rdValid <= 1'b0;
            rdData  <= 8'h00;
        end else begin
            rdValid <= |rdSel;
            if (|rdSel) rdData <= rdMux;
            if (wrSel[OFF_CTRL]) ctrl <= BUS_DATA & CTRL_WMASK;
            if (bus.PKT_VALID) begin
                status  <= bus.PKT_STATUS;
                pktCnt  <= pktCnt + 8'd1;
                prevBtn <= bus.PKT_STATUS[ST_BTN_MSB:0];
            end
            // A same-cycle read hands out the old total first.
            if (bus.PKT_VALID)
                wheel <= rdSel[OFF_WHEEL] ? dzExt
                                          : wheelSat(wheelSum);
            else if (rdSel[OFF_WHEEL])
                wheel <= 8'h00;
            if (irqSet)                     irq <= 1'b1;
            else if (bus.BUS_INTERRUPT_ACK) irq <= 1'b0;
        end
    end

    assign bus.BUS_INTERRUPT_RAISE = irq;
    assign BUS_DATA = rdValid ? rdData : 8'hzz;

endmodule

// File: tb/tb_mouse_position_tracker.sv
// Directed bench for mouse_position_tracker at default
// parameters (10-bit coordinates, 640x480).
module tb_mouse_position_tracker;
    import mouse_pkg::*;

    localparam logic [7:0] BASE = 8'hA0;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       tbDrive;
    logic [7:0] tbData;
    wire  [7:0] busData;
    int         nCompared = 0;
    int         nMismatched = 0;
    logic [7:0]  d;
    logic [15:0] v;

    mouse_position_tracker_if busIf();

    assign busData = tbDrive ? tbData : 8'hzz;

    always #5 CLK = ~CLK;

    mouse_position_tracker #(
        .BASE_ADDR(BASE),
        .COORD_W  (10),
        .LIMIT_X  (640),
        .LIMIT_Y  (480)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .bus     (busIf.slave),
        .BUS_DATA(busData)
    );

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge CLK);
    endtask

    task automatic idle;
        busIf.PKT_VALID         = 1'b0;
        busIf.BUS_ADDR          = 8'h00;
        busIf.BUS_WE            = 1'b0;
        busIf.BUS_INTERRUPT_ACK = 1'b0;
        tbDrive                 = 1'b0;
    endtask

    task automatic setPkt(
        input logic [7:0] st,
        input logic [7:0] dx,
        input logic [7:0] dy,
        input logic [3:0] dz
    );
        busIf.PKT_VALID  = 1'b1;
        busIf.PKT_STATUS = st;
        busIf.PKT_DX     = dx;
        busIf.PKT_DY     = dy;
        busIf.PKT_DZ     = dz;
    endtask

    task automatic setWr(input logic [2:0] o, input logic [7:0] x);
        busIf.BUS_ADDR = BASE + {5'b0, o};
        busIf.BUS_WE   = 1'b1;
        tbDrive        = 1'b1;
        tbData         = x;
    endtask

    task automatic pkt(
        input logic [7:0] st,
        input logic [7:0] dx,
        input logic [7:0] dy,
        input logic [3:0] dz
    );
        setPkt(st, dx, dy, dz);
        tick();
        idle();
    endtask

    task automatic wr(input logic [2:0] o, input logic [7:0] x);
        setWr(o, x);
        tick();
        idle();
    endtask

    task automatic rd(input logic [2:0] o, output logic [7:0] q);
        busIf.BUS_ADDR = BASE + {5'b0, o};
        busIf.BUS_WE   = 1'b0;
        tick();
        q = busData;
        idle();
    endtask

    task automatic rdPos(input logic isY, output logic [15:0] q);
        logic [7:0] lo, hi;
        rd(isY ? OFF_YL : OFF_XL, lo);
        rd(isY ? OFF_YH : OFF_XH, hi);
        q = {hi, lo};
    endtask

    task automatic ack;
        busIf.BUS_INTERRUPT_ACK = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        idle();
        setPkt(8'h00, 8'h00, 8'h00, 4'h0);
        busIf.PKT_VALID = 1'b0;
        tbData = 8'h00;
        RESET = 1'b0;
        repeat (3) tick();
        RESET = 1'b1;
        tick();

        check("rst_irq", busIf.BUS_INTERRUPT_RAISE, 1'b0);
        rd(OFF_XL, d);     check("rst_xl", d, 8'h40);
        rd(OFF_XH, d);     check("rst_xh", d, 8'h01);
        rd(OFF_YL, d);     check("rst_yl", d, 8'hF0);
        rd(OFF_YH, d);     check("rst_yh", d, 8'h00);
        rd(OFF_CTRL, d);   check("rst_ctrl", d, 8'h03);
        rd(OFF_PKTCNT, d); check("rst_cnt", d, 8'h00);
        rd(OFF_WHEEL, d);  check("rst_wheel", d, 8'h00);
        rd(OFF_STATUS, d); check("rst_status", d, 8'h00);

        // basic packet, Y inverted by reset CTRL
        pkt(8'h08, 8'h0A, 8'h05, 4'h0);
        check("pkt_irq", busIf.BUS_INTERRUPT_RAISE, 1'b1);
        rdPos(1'b0, v); check("pkt_x", v, 16'd330);
        rdPos(1'b1, v); check("pkt_y", v, 16'd235);
        rd(OFF_STATUS, d); check("pkt_status", d, 8'h08);
        ack();
        check("ack_irq", busIf.BUS_INTERRUPT_RAISE, 1'b0);
        busIf.BUS_INTERRUPT_ACK = 1'b1;
        pkt(8'h08, 8'h00, 8'h00, 4'h0);
        check("ack_vs_set", busIf.BUS_INTERRUPT_RAISE, 1'b1);
        ack();
        check("ack2_irq", busIf.BUS_INTERRUPT_RAISE, 1'b0);

        // sensitivity 3, overflow saturation, clamping
        wr(OFF_CTRL, 8'h0F);
        pkt(8'h48, 8'h00, 8'h00, 4'h0);
        rdPos(1'b0, v); check("ovf_pos_x", v, 16'd639);
        pkt(8'h58, 8'h00, 8'h00, 4'h0);
        rdPos(1'b0, v); check("ovf_neg_x", v, 16'd0);
        wr(OFF_YL, 8'hF0);
        wr(OFF_YH, 8'h00);
        pkt(8'h28, 8'h00, 8'hFF, 4'h0);
        rdPos(1'b1, v); check("inv_y_s3", v, 16'd248);
        rdPos(1'b0, v); check("x_still0", v, 16'd0);

        // coherent high-byte read
        wr(OFF_CTRL, 8'h03);
        wr(OFF_XL, 8'h7F);
        wr(OFF_XH, 8'h02);
        rd(OFF_XL, d); check("coh_xl", d, 8'h7F);
        pkt(8'h58, 8'h00, 8'h00, 4'h0);
        pkt(8'h18, 8'h81, 8'h00, 4'h0);
        rd(OFF_XH, d); check("coh_xh", d, 8'h02);
        rdPos(1'b0, v); check("coh_new_x", v, 16'h0100);

        // wheel accumulation and saturation
        for (int i = 0; i < 4; i++) pkt(8'h08, 8'h00, 8'h00, 4'h7);
        rd(OFF_WHEEL, d); check("wheel_28", d, 8'h1C);
        rd(OFF_WHEEL, d); check("wheel_clr", d, 8'h00);
        for (int i = 0; i < 20; i++) pkt(8'h08, 8'h00, 8'h00, 4'h7);
        rd(OFF_WHEEL, d); check("wheel_sat", d, 8'h7F);
        pkt(8'h08, 8'h00, 8'h00, 4'h3);
        busIf.BUS_ADDR = BASE + {5'b0, OFF_WHEEL};
        setPkt(8'h08, 8'h00, 8'h00, 4'hE);
        tick();
        d = busData;
        idle();
        check("wheel_rd_pkt", d, 8'h03);
        rd(OFF_WHEEL, d); check("wheel_new", d, 8'hFE);

        // commit high byte with a packet in the same cycle
        wr(OFF_XL, 8'hE8);
        setWr(OFF_XH, 8'h03);
        setPkt(8'h08, 8'h10, 8'h04, 4'h0);
        tick();
        idle();
        rdPos(1'b0, v); check("commit_x", v, 16'd639);
        rdPos(1'b1, v); check("commit_y", v, 16'd244);
        rd(OFF_PKTCNT, d); check("cnt_34", d, 8'd34);
        for (int i = 0; i < 222; i++) pkt(8'h08, 8'h00, 8'h00, 4'h0);
        rd(OFF_PKTCNT, d); check("cnt_wrap", d, 8'h00);

        // interrupt only on button change
        wr(OFF_CTRL, 8'hF3);
        ack();
        rd(OFF_CTRL, d); check("ctrl_mask", d, 8'h13);
        pkt(8'h08, 8'h00, 8'h00, 4'h0);
        check("btn_same", busIf.BUS_INTERRUPT_RAISE, 1'b0);
        pkt(8'h09, 8'h00, 8'h00, 4'h0);
        check("btn_chg", busIf.BUS_INTERRUPT_RAISE, 1'b1);
        ack();
        pkt(8'h09, 8'h00, 8'h00, 4'h0);
        check("btn_hold", busIf.BUS_INTERRUPT_RAISE, 1'b0);
        pkt(8'h08, 8'h00, 8'h00, 4'h0);
        check("btn_rel", busIf.BUS_INTERRUPT_RAISE, 1'b1);

        // reset in the middle of a packet
        setPkt(8'h09, 8'h20, 8'h20, 4'h5);
        RESET = 1'b0;
        tick();
        check("mid_rst_irq", busIf.BUS_INTERRUPT_RAISE, 1'b0);
        idle();
        tick();
        RESET = 1'b1;
        tick();
        rdPos(1'b0, v); check("mid_rst_x", v, 16'd320);
        rdPos(1'b1, v); check("mid_rst_y", v, 16'd240);
        rd(OFF_CTRL, d);   check("mid_rst_ctrl", d, 8'h03);
        rd(OFF_PKTCNT, d); check("mid_rst_cnt", d, 8'h00);
        rd(OFF_WHEEL, d);  check("mid_rst_wheel", d, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCompared, nMismatched);
        $finish;
    end

endmodule
